// File: rtl/render_pkg.sv
// Shared constants, state encoding and tile helpers
// for the board renderer.
package render_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BOARD_X0 = 120;
  localparam int BOARD_Y0 = 40;
  localparam int TILE     = 100;
  localparam int ADDR_W   = 19;

  localparam logic [3:0] EXP_MAX = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    CAPT
  } snap_state_e;

  // Which of the four tiles a board-relative offset falls in.
  function automatic logic [1:0] tile_idx(
    input logic [9:0] d
  );
    logic [1:0] r;
    r = 2'd0;
    if (d >= 10'(3 * TILE))
      r = 2'd3;
    else if (d >= 10'(2 * TILE))
      r = 2'd2;
    else if (d >= 10'(TILE))
      r = 2'd1;
    return r;
  endfunction

  // Offset inside the tile selected by tile_idx.
  function automatic logic [9:0] tile_off(
    input logic [9:0] d,
    input logic [1:0] idx
  );
    return d - (10'(idx) * 10'(TILE));
  endfunction

endpackage

// File: rtl/board_snapshot_sync.sv
// Frame-synchronous board capture: requests are only
// honoured at frame end so a frame never mixes boards.
module board_snapshot_sync
  import render_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  i_h_cnt,
  input  logic [9:0]  i_v_cnt,
  input  logic [63:0] i_board,
  input  logic        i_req,
  output logic        o_ack,
  output logic [63:0] o_snapshot
);

  snap_state_e r_state;
  snap_state_e w_state_nxt;
  logic        w_frame_end;
  logic [63:0] r_snapshot;

  assign w_frame_end =
    (i_v_cnt == 10'(V_ACTIVE)) &&
    (i_h_cnt == 10'd0);

  assign o_snapshot = r_snapshot;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state; ack is high only while in CAPT.
  always_comb begin
    w_state_nxt = r_state;
    o_ack       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_req)
          w_state_nxt = PEND;
      end
      PEND: begin
        if (!i_req)
          w_state_nxt = IDLE;
        else if (w_frame_end)
          w_state_nxt = CAPT;
      end
      CAPT: begin
        o_ack       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Snapshot loads only in CAPT, i.e. in vertical blank.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_snapshot <= '0;
    else if (r_state == CAPT)
      r_snapshot <= i_board;
  end

endmodule

// File: rtl/board_render_ctrl.sv
// Per-pixel ROM address generation and output mux,
// aligned to a 1-cycle ROM read latency.
module board_render_ctrl
  import render_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  logic [63:0]       board_in,
  input  logic              board_req,
  output logic              board_ack,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [11:0]       signal0,
  input  logic [11:0]       signal1,
  input  logic [11:0]       signal2,
  input  logic [11:0]       signal3,
  input  logic [11:0]       signal4,
  input  logic [11:0]       signal5,
  input  logic [11:0]       signal6,
  input  logic [11:0]       signal7,
  input  logic [11:0]       signal8,
  input  logic [11:0]       signal9,
  input  logic [11:0]       signal10,
  input  logic [11:0]       signal11,
  output logic [11:0]       pixel_rgb
);

  logic [63:0]       w_snapshot;
  logic              w_in_board;
  logic [9:0]        w_dx;
  logic [9:0]        w_dy;
  logic [1:0]        w_col;
  logic [1:0]        w_row;
  logic [9:0]        w_tx;
  logic [9:0]        w_ty;
  logic [3:0]        w_exp_raw;
  logic [3:0]        w_exp;
  logic [ADDR_W-1:0] w_tile_addr;
  logic [ADDR_W-1:0] w_scr_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_sel;
  logic [11:0]       w_rgb;

  logic [3:0]        r_sel_d1;
  logic              r_valid_d1;
  logic [3:0]        r_sel_d2;
  logic              r_valid_d2;

  board_snapshot_sync u_snap (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_h_cnt    (h_cnt),
    .i_v_cnt    (v_cnt),
    .i_board    (board_in),
    .i_req      (board_req),
    .o_ack      (board_ack),
    .o_snapshot (w_snapshot)
  );

  assign w_in_board =
    (h_cnt >= 10'(BOARD_X0)) &&
    (h_cnt <  10'(BOARD_X0 + 4 * TILE)) &&
    (v_cnt >= 10'(BOARD_Y0)) &&
    (v_cnt <  10'(BOARD_Y0 + 4 * TILE));

  assign w_dx  = h_cnt - 10'(BOARD_X0);
  assign w_dy  = v_cnt - 10'(BOARD_Y0);
  assign w_col = tile_idx(w_dx);
  assign w_row = tile_idx(w_dy);
  assign w_tx  = tile_off(w_dx, w_col);
  assign w_ty  = tile_off(w_dy, w_row);

  assign w_exp_raw =
    w_snapshot[{w_row, w_col, 2'b00} +: 4];
  assign w_exp =
    (w_exp_raw > EXP_MAX) ? EXP_MAX : w_exp_raw;

  assign w_tile_addr =
    ADDR_W'(w_ty) * ADDR_W'(TILE) +
    ADDR_W'(w_tx);

  // v*640 as two shifts avoids a multiplier.
  assign w_scr_addr =
    (ADDR_W'(v_cnt) << 9) +
    (ADDR_W'(v_cnt) << 7) +
    ADDR_W'(h_cnt);

  // Occupied tile cells read the tile image, else background.
  always_comb begin
    w_addr = w_scr_addr;
    w_sel  = 4'd0;
    if (w_in_board && (w_exp != 4'd0)) begin
      w_addr = w_tile_addr;
      w_sel  = w_exp;
    end
  end

  // S1: address to ROM, selection travels alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_addr <= '0;
      r_sel_d1   <= 4'd0;
      r_valid_d1 <= 1'b0;
    end else begin
      pixel_addr <= w_addr;
      r_sel_d1   <= w_sel;
      r_valid_d1 <= valid;
    end
  end

  // S2: selection aligned with ROM data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_d2   <= 4'd0;
      r_valid_d2 <= 1'b0;
    end else begin
      r_sel_d2   <= r_sel_d1;
      r_valid_d2 <= r_valid_d1;
    end
  end

  // Pick the ROM output that owns this pixel.
  always_comb begin
    w_rgb = 12'h000;
    case (r_sel_d2)
      4'd0:    w_rgb = signal0;
      4'd1:    w_rgb = signal1;
      4'd2:    w_rgb = signal2;
      4'd3:    w_rgb = signal3;
      4'd4:    w_rgb = signal4;
      4'd5:    w_rgb = signal5;
      4'd6:    w_rgb = signal6;
      4'd7:    w_rgb = signal7;
      4'd8:    w_rgb = signal8;
      4'd9:    w_rgb = signal9;
      4'd10:   w_rgb = signal10;
      4'd11:   w_rgb = signal11;
      default: w_rgb = 12'h000;
    endcase
  end

  // S3: registered colour, black outside active video.
  always_ff @(posedge clk) begin
    if (!rst_n)
      pixel_rgb <= 12'h000;
    else if (r_valid_d2)
      pixel_rgb <= w_rgb;
    else
      pixel_rgb <= 12'h000;
  end

endmodule

// File: tb/tb_board_render_ctrl.sv
// Scoreboard bench for board_render_ctrl: ROM model,
// address/colour queues and directed handshake steps.
module tb_board_render_ctrl;

  typedef struct packed {
    int          due;
    logic [18:0] v;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic [63:0] board_in;
  logic        board_req;
  logic        board_ack;
  logic [18:0] pixel_addr;
  logic [11:0] pixel_rgb;
  logic [11:0] sig [12];
  logic [18:0] rom_q;

  int   cyc = 0;
  int   last_cyc = 0;
  int   ack_cyc = -1;
  int   n_tests = 0;
  int   n_fail = 0;
  ent_t qa[$];
  ent_t qr[$];

  logic        nr;
  logic        nreq;
  logic [63:0] nb;
  logic [63:0] mboard;

  always #5 clk = ~clk;

  board_render_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .valid      (valid),
    .board_in   (board_in),
    .board_req  (board_req),
    .board_ack  (board_ack),
    .pixel_addr (pixel_addr),
    .signal0    (sig[0]),
    .signal1    (sig[1]),
    .signal2    (sig[2]),
    .signal3    (sig[3]),
    .signal4    (sig[4]),
    .signal5    (sig[5]),
    .signal6    (sig[6]),
    .signal7    (sig[7]),
    .signal8    (sig[8]),
    .signal9    (sig[9]),
    .signal10   (sig[10]),
    .signal11   (sig[11]),
    .pixel_rgb  (pixel_rgb)
  );

  function automatic logic [11:0] rom_val(
    input logic [3:0]  k,
    input logic [18:0] a
  );
    return a[11:0] ^ {k, k, k} ^ a[18:7];
  endfunction

  // ROM bank model: one-cycle read latency.
  always @(posedge clk) rom_q <= pixel_addr;

  always_comb begin
    for (int k = 0; k < 12; k++)
      sig[k] = rom_val(4'(k), rom_q);
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(
    input  int          h,
    input  int          v,
    input  logic [63:0] b,
    output logic [18:0] addr,
    output logic [3:0]  sel
  );
    int   col;
    int   row;
    logic [3:0] e;
    addr = 19'(v * 640 + h);
    sel  = 4'd0;
    if (h >= 120 && h < 520 && v >= 40 && v < 440) begin
      col = (h - 120) / 100;
      row = (v - 40) / 100;
      e = b[(row * 4 + col) * 4 +: 4];
      if (e > 4'd11) e = 4'd11;
      if (e != 4'd0) begin
        addr = 19'(((v - 40) % 100) * 100 + (h - 120) % 100);
        sel  = e;
      end
    end
  endfunction

  task automatic drive_px(
    input int   h,
    input int   v,
    input logic val
  );
    logic [18:0] a;
    logic [3:0]  s;
    @(negedge clk);
    rst_n     = nr;
    board_req = nreq;
    board_in  = nb;
    h_cnt     = 10'(h);
    v_cnt     = 10'(v);
    valid     = val;
    last_cyc  = cyc;
    model(h, v, mboard, a, s);
    if (!nr) begin
      foreach (qr[i])
        if (qr[i].due > cyc) qr[i].v = '0;
      qa.push_back('{cyc + 1, 19'd0});
      qr.push_back('{cyc + 3, 19'd0});
    end else begin
      qa.push_back('{cyc + 1, a});
      qr.push_back('{cyc + 3,
        val ? {7'd0, rom_val(s, a)} : 19'd0});
    end
  endtask

  // Scoreboard check, away from the active edge.
  always @(negedge clk) begin : chk
    ent_t e;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      e = qa.pop_front();
      n_tests++;
      assert (pixel_addr === e.v) else begin
        n_fail++;
        $error("FAIL addr cyc=%0d got=%0d exp=%0d",
               cyc, pixel_addr, e.v);
      end
    end
    while (qr.size() > 0 && qr[0].due <= cyc) begin
      e = qr.pop_front();
      n_tests++;
      assert (pixel_rgb === e.v[11:0]) else begin
        n_fail++;
        $error("FAIL rgb cyc=%0d got=%h exp=%h",
               cyc, pixel_rgb, e.v[11:0]);
      end
    end
    n_tests++;
    assert (board_ack === (cyc == ack_cyc)) else begin
      n_fail++;
      $error("FAIL ack cyc=%0d got=%b exp=%b",
             cyc, board_ack, (cyc == ack_cyc));
    end
  end

  task automatic pixels();
    drive_px(120, 40, 1'b1);
    drive_px(250, 160, 1'b1);
    drive_px(219, 139, 1'b1);
    drive_px(119, 40, 1'b1);
    drive_px(520, 40, 1'b1);
    drive_px(519, 439, 1'b1);
    drive_px(120, 439, 1'b1);
    drive_px(120, 440, 1'b1);
    drive_px(400, 300, 1'b1);
  endtask

  task automatic load_board(input logic [63:0] b);
    nb   = b;
    nreq = 1'b1;
    drive_px(200, 100, 1'b1);
    drive_px(250, 160, 1'b1);
    drive_px(120, 40, 1'b1);
    drive_px(0, 480, 1'b1);
    ack_cyc = last_cyc + 1;
    drive_px(1, 480, 1'b1);
    mboard = b;
    nreq   = 1'b0;
    drive_px(2, 480, 1'b1);
    ack_cyc = -1;
    drive_px(3, 481, 1'b1);
  endtask

  localparam logic [63:0] BOARD_A =
    64'h0002_0000_00B0_0001;
  localparam logic [63:0] BOARD_B =
    64'h3002_0000_00E0_0000;
  localparam logic [63:0] BOARD_C =
    64'h0000_0000_0050_0007;
  localparam logic [63:0] BOARD_D =
    64'h1111_1111_1111_1111;

  initial begin
    rst_n     = 1'b0;
    h_cnt     = '0;
    v_cnt     = '0;
    valid     = 1'b0;
    board_in  = '0;
    board_req = 1'b0;
    nr        = 1'b0;
    nreq      = 1'b0;
    nb        = '0;
    mboard    = '0;

    repeat (3) drive_px(10, 5, 1'b1);
    nr = 1'b1;
    drive_px(0, 0, 1'b1);
    drive_px(639, 479, 1'b1);
    drive_px(300, 200, 1'b1);
    pixels();

    load_board(BOARD_A);
    pixels();

    load_board(BOARD_B);
    pixels();

    nb   = BOARD_C;
    nreq = 1'b1;
    drive_px(0, 480, 1'b1);
    drive_px(1, 480, 1'b1);
    drive_px(5, 481, 1'b1);
    drive_px(0, 0, 1'b1);
    pixels();
    drive_px(0, 480, 1'b1);
    ack_cyc = last_cyc + 1;
    drive_px(1, 480, 1'b1);
    mboard = BOARD_C;
    nreq   = 1'b0;
    drive_px(2, 480, 1'b1);
    ack_cyc = -1;
    pixels();

    nb   = BOARD_D;
    nreq = 1'b1;
    drive_px(10, 100, 1'b1);
    drive_px(11, 100, 1'b1);
    nreq = 1'b0;
    drive_px(12, 100, 1'b1);
    drive_px(0, 480, 1'b1);
    drive_px(1, 480, 1'b1);
    pixels();

    nreq = 1'b1;
    drive_px(50, 100, 1'b1);
    drive_px(51, 100, 1'b1);
    nr   = 1'b0;
    nreq = 1'b0;
    mboard = '0;
    drive_px(52, 100, 1'b1);
    drive_px(53, 100, 1'b1);
    nr = 1'b1;
    drive_px(0, 480, 1'b1);
    drive_px(1, 480, 1'b1);
    pixels();

    load_board(BOARD_A);
    drive_px(120, 40, 1'b0);
    drive_px(250, 160, 1'b1);
    drive_px(250, 160, 1'b0);
    drive_px(300, 300, 1'b0);
    drive_px(120, 40, 1'b1);
    drive_px(600, 20, 1'b0);
    drive_px(600, 20, 1'b1);

    repeat (6) @(negedge clk);
    n_tests++;
    assert (qa.size() == 0 && qr.size() == 0) else begin
      n_fail++;
      $error("FAIL drain got=%0d exp=0",
             qa.size() + qr.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
